fifo_drain_checker: RTL
=======================

# fifo_drain_checker

Read-side controller and data checker for the 8-bit `fifo`. On `start` it drains a fixed-length burst of `BURST_LEN` bytes. It honours the FIFO's empty handshake and compares each returned byte against an incrementing expected sequence. It reports per-byte output, a sticky mismatch flag and counters, and sits between the FIFO's read port and the downstream consumer/test harness.

## Interface
- `BURST_LEN`, 16: bytes read per burst; legal range 1..65535.
- `SEED`, 8'h00: expected value of the first byte of each burst.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a burst; sampled only in IDLE.
- `fifo_is_empty` in 1: FIFO `out_is_empty`.
- `fifo_read_data` in 8: FIFO `out_read_data`, valid the cycle after a read.
- `fifo_read_ctrl` out 1: FIFO `in_read_ctrl`.
- `data_out` out 8: last checked byte.
- `data_valid` out 1: one-cycle strobe, `data_out` updated.
- `busy` out 1: high when not IDLE.
- `done` out 1: one-cycle pulse at burst completion.
- `mismatch` out 1: sticky; set on any compare failure, cleared on `start` accept or `rst`.
- `read_count` out 16: reads issued in the current burst.
- `error_count` out 8: compare failures in the current burst; saturates at 255.

## Operation
- States: IDLE, DRAIN, FLUSH, DONE.
- **IDLE**
  - On `start`=1, go to DRAIN.
  - Clear `read_count`, `error_count` and `mismatch`.
  - Load expected value with `SEED`.
- **DRAIN**
  - `fifo_read_ctrl` = !`fifo_is_empty` && (`read_count` < `BURST_LEN`). It is combinational, so the block never reads an empty FIFO.
  - Each asserted cycle increments `read_count`.
  - When the edge makes `read_count` == `BURST_LEN`, go to FLUSH.
- **FLUSH**
  - Holds one cycle so the final read's data is sampled; then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle; then go to IDLE.
- **Check pipeline**
  - A cycle with `fifo_read_ctrl`=1 registers a pending flag.
  - In the next cycle, `fifo_read_data` is compared against the expected value.
  - On that edge: `data_out` <= `fifo_read_data`; `data_valid` <= 1.
  - If the compare fails: `mismatch` <= 1 and `error_count` increments (saturating).
  - Expected value increments modulo 256 after every check, whether it passed or failed.
- `start` outside IDLE is ignored.
- `fifo_read_ctrl` is 0 in IDLE, FLUSH and DONE.

## Timing
- Reset values: `fifo_read_ctrl`=0, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0, `mismatch`=0, `read_count`=0, `error_count`=0, state IDLE, expected=`SEED`.
- `rst` mid-burst aborts immediately. Pending checks are discarded and no `done` is pulsed.
- Read latency: read issued in cycle t → byte on `fifo_read_data` in t+1 → `data_valid` high in t+2.
- Back-to-back reads sustain 1 byte/cycle while the FIFO is non-empty. The FIFO's registered `out_is_empty` updates in time, so no extra bubble is inserted.
- FIFO empty mid-burst:
  - DRAIN stalls with `fifo_read_ctrl`=0 and no timeout.
  - Reads resume the cycle `fifo_is_empty` falls.
- `start` accepted at edge e: first possible read in cycle e+1.
- Last read in cycle t: FLUSH in t+1, last `data_valid` in t+2, `done` pulse in t+2, `busy`=0 from t+3.
- `BURST_LEN`=1 passes through DRAIN for exactly one read.
- Expected value wraps 8'hFF→8'h00 without error.

## Structure
- Package `fifo_pkg` holds:
  - state enum `drain_state_t`;
  - `BYTE_W`=8;
  - `CNT_W`=16;
  - `ERR_MAX`=255.
- Sub-module `seq_checker`: expected-value register, compare, `mismatch`/`error_count` logic. Inputs are `load`, `sample` and `byte`.
- Top level holds the FSM, `read_count` and the read handshake.

## Test plan
- `BURST_LEN`=4, FIFO preloaded with 00,01,02,03, `start` pulse → four consecutive `fifo_read_ctrl` cycles; `data_valid` on 00..03; `mismatch`=0; `done` pulse 2 cycles after the last read.
- FIFO holds 2 bytes and the remaining 2 arrive 5 cycles later → `fifo_read_ctrl` drops while empty, never asserts with `fifo_is_empty`=1, and the burst completes with `read_count`=4.
- Data 00,01,07,03 → `mismatch` set at the third `data_valid`; `error_count`=1; the fourth byte passes.
- `SEED`=8'hFE, data FE,FF,00,01 → no mismatch across the wrap.
- `rst` asserted in the second cycle of DRAIN → all outputs return to reset values asynchronously, with no `done`. A following `start` runs cleanly.
- All 300 bytes wrong with `BURST_LEN`=300 → `error_count` saturates at 255; `mismatch`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side drain checker.
package fifo_pkg;

  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 16;
  localparam int ERR_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } drain_state_t;

  // Error counter increment that sticks at ERR_MAX instead of wrapping.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return (v == BYTE_W'(ERR_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_drain_checker_seq_checker.sv
// Expected-sequence checker: compares each returned byte against an
// incrementing reference and keeps the sticky mismatch flag and error count.
module seq_checker
  import fifo_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SEED = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              sample_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] data_out_o,
  output logic              data_valid_o,
  output logic              mismatch_o,
  output logic [BYTE_W-1:0] error_count_o
);

  logic [BYTE_W-1:0] expected_q, expected_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              mismatch_q, mismatch_d;
  logic [BYTE_W-1:0] err_q, err_d;

  always_comb begin
    expected_d   = expected_q;
    data_out_d   = data_out_q;
    mismatch_d   = mismatch_q;
    err_d        = err_q;
    data_valid_d = 1'b0;
    if (load_i) begin
      expected_d = SEED;
      mismatch_d = 1'b0;
      err_d      = '0;
    end else if (sample_i) begin
      data_out_d   = byte_i;
      data_valid_d = 1'b1;
      // The reference advances even on a failed compare, so one bad byte
      // does not cascade into errors on every following byte.
      expected_d   = expected_q + 8'd1;
      if (byte_i != expected_q) begin
        mismatch_d = 1'b1;
        err_d      = sat_inc(err_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q   <= SEED;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      expected_q   <= expected_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      mismatch_q   <= mismatch_d;
      err_q        <= err_d;
    end
  end

  assign data_out_o    = data_out_q;
  assign data_valid_o  = data_valid_q;
  assign mismatch_o    = mismatch_q;
  assign error_count_o = err_q;

endmodule

// File: rtl/fifo_drain_checker.sv
// Drains a fixed-length burst from the FIFO read port on start and checks
// every returned byte against an incrementing sequence.
module fifo_drain_checker
  import fifo_pkg::*;
#(
  parameter int                BURST_LEN = 16,
  parameter logic [BYTE_W-1:0] SEED      = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo_is_empty,
  input  logic [BYTE_W-1:0] fifo_read_data,
  output logic              fifo_read_ctrl,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  read_count,
  output logic [BYTE_W-1:0] error_count,
  output drain_state_t      state_dbg
);

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  drain_state_t     state_q;
  logic [CNT_W-1:0] read_count_q;
  logic             pending_q;
  logic             done_q;
  logic             start_acc;

  // Read handshake: a read is issued in any cycle where fifo_read_ctrl is high
  // and the FIFO is non-empty; the byte appears on fifo_read_data the next
  // cycle, where pending_q marks it for checking. There is no backpressure.
  assign fifo_read_ctrl = (state_q == ST_DRAIN) && !fifo_is_empty &&
                          (read_count_q < BURST_CNT);
  assign start_acc      = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      read_count_q <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pending_q <= fifo_read_ctrl;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            read_count_q <= '0;
            state_q      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_read_ctrl) begin
            read_count_q <= read_count_q + 16'd1;
            if (read_count_q + 16'd1 == BURST_CNT) state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  seq_checker #(.SEED(SEED)) u_checker (
    .clk           (clk),
    .rst           (rst),
    .load_i        (start_acc),
    .sample_i      (pending_q),
    .byte_i        (fifo_read_data),
    .data_out_o    (data_out),
    .data_valid_o  (data_valid),
    .mismatch_o    (mismatch),
    .error_count_o (error_count)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign read_count = read_count_q;
  assign state_dbg  = state_q;

endmodule
